// File: rtl/seat_request_ctrl.sv
// Front-end controller for the seat table: accepts requests, runs the minute
// timebase, sequences check-then-write and returns one result per request.
module seat_request_ctrl #(
  parameter int unsigned TICKS_PER_MIN   = 50000000,
  parameter int unsigned MINUTES_PER_DAY = 1440,
  parameter int unsigned NUM_SEATS       = 32,
  parameter int unsigned LIMIT_MIN       = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_student_no,
  input  logic [4:0]  req_seat_no,
  input  logic [1:0]  req_action,
  input  logic        clear_all,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_ok,
  output logic [1:0]  resp_code,
  output logic        rst_mem,
  output logic        write_mem,
  output logic [31:0] Student_No_mem,
  output logic [10:0] Time_mem,
  output logic [1:0]  Seat_State_mem,
  output logic [4:0]  Seat_No_mem,
  output logic [10:0] limit_time,
  input  logic        Do_Not_Seat
);

  localparam int unsigned PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [10:0]   MIN_LAST   = 11'(MINUTES_PER_DAY - 1);

  localparam logic [1:0] ACT_SIT     = 2'd2;
  localparam logic [1:0] ACT_ILLEGAL = 2'd3;

  localparam logic [1:0] CODE_OK       = 2'd0;
  localparam logic [1:0] CODE_OCCUPIED = 2'd1;
  localparam logic [1:0] CODE_BAD_REQ  = 2'd2;
  localparam logic [1:0] CODE_ABORTED  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_RESP
  } state_e;

  // Timebase
  logic [PW-1:0] presc_q, presc_d;
  logic [10:0]   minute_q, minute_d;
  logic          min_tick;
  logic          day_wrap;
  logic          clr_evt;

  always_comb begin
    min_tick = (presc_q == PRESC_LAST);
    day_wrap = min_tick && (minute_q == MIN_LAST);
    presc_d  = min_tick ? '0 : presc_q + PW'(1);
    minute_d = minute_q;
    if (min_tick) begin
      minute_d = day_wrap ? 11'd0 : minute_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      minute_q <= '0;
    end else begin
      presc_q  <= presc_d;
      minute_q <= minute_d;
    end
  end

  // Any table-wipe event; also aborts an in-flight check/write.
  assign clr_evt = clear_all || day_wrap;

  // Request FSM
  state_e      state_q, state_d;
  logic [31:0] student_q, student_d;
  logic [4:0]  seat_q, seat_d;
  logic [1:0]  action_q, action_d;
  logic        write_q, write_d;
  logic        rst_mem_q, rst_mem_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_ok_q, resp_ok_d;
  logic [1:0]  resp_code_q, resp_code_d;

  assign req_ready = (state_q == S_IDLE) && !clr_evt;

  always_comb begin
    state_d      = state_q;
    student_d    = student_q;
    seat_d       = seat_q;
    action_d     = action_q;
    write_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_ok_d    = resp_ok_q;
    resp_code_d  = resp_code_q;
    rst_mem_d    = clr_evt || (state_q == S_INIT);

    case (state_q)
      S_INIT: state_d = S_IDLE;

      S_IDLE: begin
        if (req_valid && req_ready) begin
          student_d = req_student_no;
          seat_d    = req_seat_no;
          action_d  = req_action;
          if ((req_action == ACT_ILLEGAL) || (32'(req_seat_no) >= NUM_SEATS)) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_ok_d    = 1'b0;
            resp_code_d  = CODE_BAD_REQ;
          end else begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (clr_evt) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b0;
          resp_code_d  = CODE_ABORTED;
        end else if (Do_Not_Seat && (action_q == ACT_SIT)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b0;
          resp_code_d  = CODE_OCCUPIED;
        end else begin
          state_d = S_WRITE;
          write_d = 1'b1;
        end
      end

      // Do_Not_Seat is not looked at here: it rises as a result of a sit write.
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_ok_d    = !clr_evt;
        resp_code_d  = clr_evt ? CODE_ABORTED : CODE_OK;
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      student_q    <= '0;
      seat_q       <= '0;
      action_q     <= '0;
      write_q      <= 1'b0;
      rst_mem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      student_q    <= student_d;
      seat_q       <= seat_d;
      action_q     <= action_d;
      write_q      <= write_d;
      rst_mem_q    <= rst_mem_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_code_q  <= resp_code_d;
    end
  end

  // A wipe arriving during the write cycle must not let the strobe through.
  assign write_mem      = write_q && !clr_evt;
  assign rst_mem        = rst_mem_q;
  assign resp_valid     = resp_valid_q;
  assign resp_ok        = resp_ok_q;
  assign resp_code      = resp_code_q;
  assign Student_No_mem = student_q;
  assign Seat_No_mem    = seat_q;
  assign Seat_State_mem = action_q;
  assign Time_mem       = minute_q;
  assign limit_time     = 11'(LIMIT_MIN);

endmodule

// File: tb/tb_seat_request_ctrl.sv
// Directed bench for seat_request_ctrl with a fast timebase (4 clk/min, 8 min/day)
// and 30 seats, so day wraps and seat-range limits are reachable quickly.
module tb_seat_request_ctrl;

  localparam int TPM = 4;
  localparam int MPD = 8;
  localparam int NS  = 30;
  localparam int LIM = 30;
  localparam int DAY = TPM * MPD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_student_no;
  logic [4:0]  req_seat_no;
  logic [1:0]  req_action;
  logic        clear_all;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_ok;
  logic [1:0]  resp_code;
  logic        rst_mem;
  logic        write_mem;
  logic [31:0] Student_No_mem;
  logic [10:0] Time_mem;
  logic [1:0]  Seat_State_mem;
  logic [4:0]  Seat_No_mem;
  logic [10:0] limit_time;
  logic        Do_Not_Seat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];

  seat_request_ctrl #(
    .TICKS_PER_MIN(TPM),
    .MINUTES_PER_DAY(MPD),
    .NUM_SEATS(NS),
    .LIMIT_MIN(LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_student_no(req_student_no),
    .req_seat_no(req_seat_no),
    .req_action(req_action),
    .clear_all(clear_all),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_ok(resp_ok),
    .resp_code(resp_code),
    .rst_mem(rst_mem),
    .write_mem(write_mem),
    .Student_No_mem(Student_No_mem),
    .Time_mem(Time_mem),
    .Seat_State_mem(Seat_State_mem),
    .Seat_No_mem(Seat_No_mem),
    .limit_time(limit_time),
    .Do_Not_Seat(Do_Not_Seat)
  );

  // Clock / reset-relative cycle counter (posedges since reset release)
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  function automatic logic [10:0] exp_time();
    return 11'((cyc / TPM) % MPD);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where cyc % DAY == ph (bounded).
  task automatic wait_phase(input int ph);
    for (int i = 0; i < DAY + 4; i++) begin
      if ((cyc % DAY) == ph) return;
      @(negedge clk);
    end
    check("sync_timeout", 64'd0, 64'd1);
  endtask

  // Driver: one request, then observe the response path cycle by cycle.
  // exp_lat: cycles from accept to resp_valid; exp_wr: cycle of write_mem (-1 none).
  task automatic do_req(input string tag, input logic [31:0] stu, input logic [4:0] seat,
                        input logic [1:0] act, input logic dns_check, input logic dns_write,
                        input logic clr_check, input int exp_lat, input int exp_wr,
                        input logic [2:0] exp_resp, input logic exp_rst, input int hold);
    int lat;
    int wr_at;
    logic rst_seen;
    logic [2:0] exp;
    exp_q.push_back(exp_resp);
    req_valid      = 1'b1;
    req_student_no = stu;
    req_seat_no    = seat;
    req_action     = act;
    #1;
    check({tag, " accept_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    wr_at = -1;
    rst_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 1) begin
        Do_Not_Seat = dns_check;
        clear_all   = clr_check;
      end else begin
        Do_Not_Seat = dns_write;
        clear_all   = 1'b0;
      end
      #1;
      if (i == 1) begin
        check({tag, " student_reg"}, 64'(Student_No_mem), 64'(stu));
        check({tag, " seat_reg"}, 64'(Seat_No_mem), 64'(seat));
        check({tag, " action_reg"}, 64'(Seat_State_mem), 64'(act));
        check({tag, " busy_ready"}, 64'(req_ready), 64'd0);
      end
      if (write_mem) begin
        wr_at = i;
        check({tag, " write_time"}, 64'(Time_mem), 64'(exp_time()));
        check({tag, " write_student"}, 64'(Student_No_mem), 64'(stu));
      end
      if (rst_mem) rst_seen = 1'b1;
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    Do_Not_Seat = 1'b0;
    clear_all   = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " resp_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " write_cycle"}, 64'(wr_at), 64'(exp_wr));
    check({tag, " rst_mem_pulse"}, 64'(rst_seen), 64'(exp_rst));
    check({tag, " resp_ok_code"}, 64'({resp_ok, resp_code}), 64'(exp));
    check({tag, " resp_ready_low"}, 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check({tag, " hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, " hold_code"}, 64'({resp_ok, resp_code}), 64'(exp));
      check({tag, " hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    #1;
    check({tag, " handshake_ready"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check({tag, " resp_dropped"}, 64'(resp_valid), 64'd0);
    check({tag, " idle_ready"}, 64'(req_ready), 64'd1);
    check({tag, " fields_kept"}, 64'(Student_No_mem), 64'(stu));
  endtask

  initial begin
    int pulses;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_student_no = '0;
    req_seat_no    = '0;
    req_action     = '0;
    clear_all      = 1'b0;
    resp_ready     = 1'b0;
    Do_Not_Seat    = 1'b0;

    // Reset: everything registered is 0, not ready.
    repeat (3) @(negedge clk);
    check("rst write_mem", 64'(write_mem), 64'd0);
    check("rst rst_mem", 64'(rst_mem), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_ok_code", 64'({resp_ok, resp_code}), 64'd0);
    check("rst fields", 64'({Student_No_mem, Seat_State_mem, Seat_No_mem}), 64'd0);
    check("rst time", 64'(Time_mem), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init rst_mem pulse", 64'(rst_mem), 64'd1);
    @(negedge clk);
    check("post init rst_mem", 64'(rst_mem), 64'd0);
    check("post init req_ready", 64'(req_ready), 64'd1);
    check("limit_time", 64'(limit_time), 64'(LIM));

    // Timebase over one full day, starting at cyc=2.
    pulses = 0;
    for (int i = 0; i < DAY; i++) begin
      check($sformatf("time cyc%0d", cyc), 64'(Time_mem), 64'(exp_time()));
      check($sformatf("wrap pulse cyc%0d", cyc), 64'(rst_mem), 64'((cyc % DAY) == 0));
      if (rst_mem) pulses++;
      @(negedge clk);
    end
    check("wrap pulse count", 64'(pulses), 64'd1);

    wait_phase(2);
    do_req("sit", 32'h2023_0001, 5'd5, 2'd2, 1'b0, 1'b1, 1'b0, 3, 2, 3'b1_00, 1'b0, 0);
    wait_phase(2);
    do_req("occupied", 32'h2023_0002, 5'd5, 2'd2, 1'b1, 1'b1, 1'b0, 2, -1, 3'b0_01, 1'b0, 0);
    do_req("away", 32'h2023_0001, 5'd5, 2'd1, 1'b1, 1'b1, 1'b0, 3, 2, 3'b1_00, 1'b0, 0);
    wait_phase(2);
    do_req("seat31", 32'h0000_0031, 5'd31, 2'd2, 1'b0, 1'b0, 1'b0, 1, -1, 3'b0_10, 1'b0, 5);
    do_req("illegal", 32'h0000_0003, 5'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1, -1, 3'b0_10, 1'b0, 0);
    wait_phase(2);
    do_req("seat30", 32'h0000_0030, 5'd30, 2'd0, 1'b0, 1'b0, 1'b0, 1, -1, 3'b0_10, 1'b0, 0);
    do_req("seat29", 32'h0000_0029, 5'd29, 2'd0, 1'b0, 1'b0, 1'b0, 3, 2, 3'b1_00, 1'b0, 0);
    wait_phase(2);
    do_req("clr_check", 32'hABCD_0007, 5'd7, 2'd2, 1'b0, 1'b0, 1'b1, 2, -1, 3'b0_11, 1'b1, 0);
    do_req("after_clr", 32'hABCD_0008, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0, 3, 2, 3'b1_00, 1'b0, 0);

    // Day wrap lands on the CHECK cycle of this request.
    wait_phase(DAY - 2);
    do_req("wrap_abort", 32'h0000_0009, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0, 2, -1, 3'b0_11, 1'b1, 0);

    // clear_all in IDLE blocks acceptance in that cycle.
    wait_phase(2);
    clear_all      = 1'b1;
    req_valid      = 1'b1;
    req_student_no = 32'hDEAD_BEEF;
    req_seat_no    = 5'd1;
    req_action     = 2'd2;
    #1;
    check("idle_clr ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    clear_all = 1'b0;
    req_valid = 1'b0;
    #1;
    check("idle_clr rst_mem", 64'(rst_mem), 64'd1);
    check("idle_clr not_accepted", 64'(req_ready), 64'd1);
    check("idle_clr fields", 64'(Student_No_mem), 64'h0000_0009);
    @(negedge clk);
    check("idle_clr pulse_end", 64'(rst_mem), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seat_request_ctrl.md
Name: seat_request_ctrl

Overview:
- Front-end controller that sits directly upstream of the seat-table memory stage.
- Accepts seat requests (student number, seat number, action) over a valid/ready handshake.
- Runs the minute time-of-day counter and sequences each request as check-then-write against the table. It drives the table's write strobe and clear pulse, samples the table's Do_Not_Seat flag, and returns a per-request result over a valid/ready response handshake.

Parameters:
- TICKS_PER_MIN, default 50000000: clk cycles per minute tick; legal range ≥1.
- MINUTES_PER_DAY, default 1440: minute counter wraps to 0 after MINUTES_PER_DAY-1; must be ≤2048.
- NUM_SEATS, default 32: seat numbers ≥ NUM_SEATS are rejected.
- LIMIT_MIN, default 30: away-timeout in minutes, driven on limit_time; must be ≤2047.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_student_no  in  32  student number.
- req_seat_no  in  5  seat index.
- req_action  in  2  0=leave, 1=away, 2=sit, 3=illegal.
- clear_all  in  1  single-cycle request to wipe all seat tables.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_ok  out  1  1 = table written.
- resp_code  out  2  0=OK, 1=OCCUPIED, 2=BAD_REQ, 3=ABORTED.
- rst_mem  out  1  table clear pulse.
- write_mem  out  1  table write strobe.
- Student_No_mem  out  32  registered student number.
- Time_mem  out  11  current minute, zero-extended.
- Seat_State_mem  out  2  registered action.
- Seat_No_mem  out  5  registered seat index.
- limit_time  out  11  constant LIMIT_MIN.
- Do_Not_Seat  in  1  combinational occupancy flag from the table.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs are 0: write_mem, rst_mem, resp_valid, resp_ok, resp_code, the four *_mem fields, minute counter and prescaler.
  - req_ready is 0. FSM enters INIT.
- Timebase:
  - Prescaler counts 0..TICKS_PER_MIN-1; at the terminal count the minute counter increments.
  - Minute counter goes from MINUTES_PER_DAY-1 to 0; this wrap raises a day_wrap event for one cycle.
  - Time_mem shows the minute register directly and updates the cycle after the tick.
- rst_mem is a registered single-cycle pulse, asserted the cycle after any of:
  - INIT,
  - clear_all=1,
  - day_wrap.
  - Coincident events produce one pulse.
- FSM states: INIT, IDLE, CHECK, WRITE, RESP.
- INIT: lasts one cycle (this is the post-reset clear pulse), then goes to IDLE.
- IDLE:
  - req_ready=1 unless a clear/wrap event occurs in the same cycle.
  - On req_valid&&req_ready, register student, seat and action into the *_mem outputs.
  - If action=3 or seat≥NUM_SEATS: go to RESP with code 2. Otherwise go to CHECK.
- CHECK (1 cycle):
  - Fields are stable and write_mem=0. Do_Not_Seat is sampled at the end of this cycle.
  - If Do_Not_Seat=1 and action=2: go to RESP with code 1.
  - Otherwise go to WRITE.
- WRITE (1 cycle):
  - write_mem=1 for exactly this cycle. Do_Not_Seat is ignored here, because it legitimately rises after a sit write.
  - Then go to RESP with code 0, resp_ok=1.
- RESP:
  - resp_valid=1, and resp_ok/resp_code stay stable until resp_ready.
  - On resp_valid&&resp_ready go to IDLE; the *_mem fields keep their last values.
- Abort: if clear_all or day_wrap occurs while in CHECK or WRITE:
  - write_mem is suppressed (forced 0 in that cycle).
  - Go to RESP with resp_ok=0, code 3.
  - rst_mem still pulses.
- Latency: accept at cycle N → write_mem at N+2 → resp_valid at N+3. Throughput is at most one request per 4 cycles with resp_ready held high.
- Back-to-back: req_ready=0 in CHECK, WRITE and RESP; req_ready is never asserted in the same cycle as resp_valid.
- Width rules:
  - Time_mem is 11 bits.
  - The table computes elapsed time modulo 2048. No correction is applied across day wrap, since tables are cleared there.

Test Plan:
- rst_n low for 3 cycles, then high → all outputs 0 during reset; rst_mem=1 in the first cycle after release; req_ready=1 from the next cycle.
- TICKS_PER_MIN=4, MINUTES_PER_DAY=8; run 32 cycles → Time_mem steps 0..7, returns to 0; one rst_mem pulse coincides with the wrap.
- Request (0x20230001, seat 5, action 2) with Do_Not_Seat=0 → write_mem high exactly at N+2 with fields 0x20230001/5/2/current time; resp_ok=1, code 0 at N+3.
- Same seat, action 2, Do_Not_Seat=1 during CHECK → no write_mem; resp code 1. Repeat with action 1 → write occurs, code 0.
- Seat 31 with NUM_SEATS=30, and separately action=3 → no CHECK and no write; code 2 at N+1. Hold resp_ready=0 for 5 cycles → resp_valid held and req_ready stays 0.
- clear_all pulsed in the CHECK cycle → rst_mem pulse, write_mem never asserted, resp code 3; the next request is accepted normally.
